// File: rtl/ram_responder.sv
// Big-endian byte-addressable data memory behind the MDR.
// Completes each access with a MOV/MFC four-phase handshake.
module ram_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] dout_n;
  logic mfc_n, err_n;
  logic cap;

  logic              rw_q, sx_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  logic [7:0] mem [2**ADDR_W];

  // Aligned accesses never carry out of the low two bits, so OR-in works
  logic [ADDR_W-1:0] a1, a2, a3;
  assign a1 = {addr_q[ADDR_W-1:1], 1'b1};
  assign a2 = {addr_q[ADDR_W-1:2], 2'b10};
  assign a3 = {addr_q[ADDR_W-1:2], 2'b11};

  logic [7:0] b0, b1, b2, b3;
  assign b0 = mem[addr_q];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  logic bad;
  always_comb begin
    bad = 1'b0;
    unique case (size_q)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_q[0];
      2'b10:   bad = |addr_q[1:0];
      default: bad = 1'b1;
    endcase
  end

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    unique case (size_q)
      2'b00:   rdata = {{24{sx_q & b0[7]}}, b0};
      2'b01:   rdata = {{16{sx_q & b0[7]}}, b0, b1};
      default: rdata = {b0, b1, b2, b3};
    endcase
  end

  logic commit, wr_en;
  assign commit = (state == S_WAIT) && (cnt == 4'd0);
  assign wr_en  = commit && !rw_q && !bad;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = DataOut;
    mfc_n   = MFC;
    err_n   = Err;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (MOV) begin
          cap     = 1'b1;
          cnt_n   = 4'(LATENCY);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          mfc_n   = 1'b1;
          err_n   = bad;
          state_n = S_RESP;
          if (rw_q && !bad) dout_n = rdata;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (!MOV) begin
          mfc_n   = 1'b0;
          err_n   = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      DataOut <= '0;
      MFC     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      DataOut <= dout_n;
      MFC     <= mfc_n;
      Err     <= err_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q   <= 1'b0;
      sx_q   <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (cap) begin
      rw_q   <= RW;
      sx_q   <= SignExt;
      size_q <= Size;
      addr_q <= Address;
      din_q  <= DataIn;
    end
  end

  // Array is deliberately left out of reset; reset forces IDLE so no write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      unique case (size_q)
        2'b00: mem[addr_q] <= din_q[7:0];
        2'b01: begin
          mem[addr_q] <= din_q[15:8];
          mem[a1]     <= din_q[7:0];
        end
        2'b10: begin
          mem[addr_q] <= din_q[31:24];
          mem[a1]     <= din_q[23:16];
          mem[a2]     <= din_q[15:8];
          mem[a3]     <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed scoreboard bench for ram_responder.
// Expected data comes from a byte-array reference model.
module tb_ram_responder;

  localparam int AW  = 9;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          MOV;
  logic          RW;
  logic [1:0]    Size;
  logic          SignExt;
  logic [AW-1:0] Address;
  logic [31:0]   DataIn;
  logic [31:0]   DataOut;
  logic          MFC;
  logic          Err;

  ram_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .MOV     (MOV),
    .RW      (RW),
    .Size    (Size),
    .SignExt (SignExt),
    .Address (Address),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .MFC     (MFC),
    .Err     (Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        sbq [$];
  logic [7:0]  m [2**AW];
  logic [31:0] mdout;
  int          checks;
  int          fails;
  logic [31:0] got;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_req(input logic [1:0] sz, input int a);
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
           (sz == 2'b10 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] mrd(input logic [1:0] sz,
                                      input logic sx, input int a);
    logic [31:0] w;
    case (sz)
      2'b00: begin
        w = {24'h0, m[a]};
        if (sx && m[a][7]) w[31:8] = '1;
      end
      2'b01: begin
        w = {16'h0, m[a], m[a+1]};
        if (sx && m[a][7]) w[31:16] = '1;
      end
      default: w = {m[a], m[a+1], m[a+2], m[a+3]};
    endcase
    return w;
  endfunction

  task automatic mwr(input logic [1:0] sz, input int a,
                     input logic [31:0] v);
    case (sz)
      2'b00: m[a] = v[7:0];
      2'b01: begin
        m[a] = v[15:8]; m[a+1] = v[7:0];
      end
      default: begin
        m[a] = v[31:24]; m[a+1] = v[23:16];
        m[a+2] = v[15:8]; m[a+3] = v[7:0];
      end
    endcase
  endtask

  task automatic access(input string tag, input logic rw,
                        input logic [1:0] sz, input logic sx,
                        input logic [AW-1:0] a, input logic [31:0] din,
                        input int hold, output logic [31:0] obs);
    exp_t e;
    int n;
    e.e = bad_req(sz, int'(a));
    e.d = (!e.e && rw) ? mrd(sz, sx, int'(a)) : mdout;
    if (!e.e && !rw) mwr(sz, int'(a), din);
    mdout = e.d;
    sbq.push_back(e);
    MOV = 1'b1; RW = rw; Size = sz; SignExt = sx;
    Address = a; DataIn = din;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        RW = ~rw; Size = 2'($urandom); SignExt = ~sx;
        Address = AW'($urandom); DataIn = $urandom;
      end
    end while (!MFC && n < 64);
    chk({tag, ".latency"}, 32'(n), 32'(LAT + 2));
    e = sbq.pop_front();
    chk({tag, ".data"}, DataOut, e.d);
    chk({tag, ".err"}, 32'(Err), 32'(e.e));
    obs = DataOut;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_mfc"}, 32'(MFC), 32'd1);
      chk({tag, ".hold_data"}, DataOut, e.d);
    end
    MOV = 1'b0;
    @(negedge clk);
    chk({tag, ".mfc_drop"}, 32'(MFC), 32'd0);
    chk({tag, ".err_drop"}, 32'(Err), 32'd0);
    chk({tag, ".data_keep"}, DataOut, e.d);
  endtask

  initial begin
    checks = 0; fails = 0; mdout = '0;
    reset_n = 1'b0; MOV = 1'b0; RW = 1'b0; Size = '0;
    SignExt = 1'b0; Address = '0; DataIn = '0;
    repeat (2) @(negedge clk);
    chk("reset.data", DataOut, 32'h0);
    chk("reset.mfc", 32'(MFC), 32'd0);
    chk("reset.err", 32'(Err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    access("pre4", 1'b0, 2'b10, 1'b0, 9'h004, 32'h01020304, 0, got);
    access("pre8", 1'b0, 2'b10, 1'b0, 9'h008, 32'h05060708, 0, got);
    access("pre20", 1'b0, 2'b10, 1'b0, 9'h020, 32'h12345678, 0, got);

    access("w4", 1'b0, 2'b10, 1'b0, 9'h004, 32'hDEADBEEF, 0, got);
    access("r4", 1'b1, 2'b10, 1'b0, 9'h004, 32'h0, 0, got);
    chk("r4.const", got, 32'hDEADBEEF);
    access("rb4", 1'b1, 2'b00, 1'b0, 9'h004, 32'h0, 0, got);
    chk("rb4.const", got, 32'h000000DE);

    access("wb10", 1'b0, 2'b00, 1'b0, 9'h010, 32'h00000085, 0, got);
    access("rb10s", 1'b1, 2'b00, 1'b1, 9'h010, 32'h0, 0, got);
    chk("rb10s.const", got, 32'hFFFFFF85);
    access("rb10z", 1'b1, 2'b00, 1'b0, 9'h010, 32'h0, 0, got);
    chk("rb10z.const", got, 32'h00000085);
    access("wh12", 1'b0, 2'b01, 1'b0, 9'h012, 32'h00008001, 0, got);
    access("rh12s", 1'b1, 2'b01, 1'b1, 9'h012, 32'h0, 0, got);
    chk("rh12s.const", got, 32'hFFFF8001);
    access("rh12z", 1'b1, 2'b01, 1'b0, 9'h012, 32'h0, 0, got);
    chk("rh12z.const", got, 32'h00008001);

    access("hold", 1'b1, 2'b10, 1'b0, 9'h008, 32'h0, 5, got);
    @(negedge clk);
    chk("hold.no_rerun", 32'(MFC), 32'd0);

    access("mis6", 1'b0, 2'b10, 1'b0, 9'h006, 32'h11223344, 0, got);
    access("mis.r4", 1'b1, 2'b10, 1'b0, 9'h004, 32'h0, 0, got);
    chk("mis.r4.const", got, 32'hDEADBEEF);
    access("mis.r8", 1'b1, 2'b10, 1'b0, 9'h008, 32'h0, 0, got);
    chk("mis.r8.const", got, 32'h05060708);
    access("mish3", 1'b1, 2'b01, 1'b0, 9'h003, 32'h0, 0, got);
    chk("mish3.const", got, 32'h05060708);
    access("size3", 1'b1, 2'b11, 1'b0, 9'h000, 32'h0, 0, got);

    MOV = 1'b1; RW = 1'b0; Size = 2'b10; SignExt = 1'b0;
    Address = 9'h020; DataIn = 32'hCAFEF00D;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort.mfc", 32'(MFC), 32'd0);
    chk("abort.data", DataOut, 32'h0);
    mdout = '0;
    MOV = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    access("abort.r20", 1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 0, got);
    chk("abort.r20.const", got, 32'h12345678);

    access("w30", 1'b0, 2'b10, 1'b0, 9'h030, 32'hAABBCCDD, 0, got);
    access("wb32", 1'b0, 2'b00, 1'b0, 9'h032, 32'h00000011, 0, got);
    access("r30", 1'b1, 2'b10, 1'b0, 9'h030, 32'h0, 0, got);
    chk("r30.const", got, 32'hAABB11DD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
